// File: rtl/bram_stream_pkg.sv
// Shared types and constants for the BRAM burst reader and its output buffer.
package bram_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int BUF_DEPTH       = 2;
  localparam int BUF_COUNT_WIDTH = $clog2(BUF_DEPTH + 1);
  localparam int BUF_PTR_WIDTH   = $clog2(BUF_DEPTH);

endpackage

// File: rtl/bram_stream_skid.sv
// Two-entry FIFO between the RAM read port and the stream output.
// It accepts a write and a pop in the same cycle so the stream can run at full rate.
module bram_stream_skid
  import bram_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8
)
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       valid,
  output logic [BUF_COUNT_WIDTH-1:0] count
);

  logic [DATA_WIDTH-1:0]      mem [BUF_DEPTH];
  logic [BUF_PTR_WIDTH-1:0]   wr_ptr;
  logic [BUF_PTR_WIDTH-1:0]   rd_ptr;
  logic [BUF_COUNT_WIDTH-1:0] count_q;
  logic                       do_pop;

  assign do_pop  = rd_en && (count_q != '0);
  assign valid   = (count_q != '0);
  assign count   = count_q;
  assign rd_data = mem[rd_ptr];

  // The reader never writes into a full buffer, so no overflow guard is needed here.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!wr_en && do_pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Reads a burst of consecutive words from a registered-read BRAM and streams
// them out with valid/ready flow control, marking the final word with out_last.
module bram_stream_reader
  import bram_stream_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 10
)
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH:0]   length,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] ram_raddr,
  output logic                     ram_re,
  input  logic [DATA_WIDTH-1:0]    ram_rdata,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last
);

  localparam logic [BUF_COUNT_WIDTH:0] BUF_LIMIT = (BUF_COUNT_WIDTH + 1)'(BUF_DEPTH);
  localparam logic [ADDRESS_WIDTH:0]   ONE_LEFT  = (ADDRESS_WIDTH + 1)'(1);

  state_t                     state;
  state_t                     state_next;
  logic [ADDRESS_WIDTH-1:0]   addr;
  logic [ADDRESS_WIDTH-1:0]   addr_next;
  logic [ADDRESS_WIDTH:0]     issue_left;
  logic [ADDRESS_WIDTH:0]     issue_left_next;
  logic [ADDRESS_WIDTH:0]     out_left;
  logic [ADDRESS_WIDTH:0]     out_left_next;
  logic                       in_flight;
  logic                       done_next;
  logic                       pop;
  logic [BUF_COUNT_WIDTH-1:0] buf_count;
  logic [BUF_COUNT_WIDTH:0]   occupancy;

  assign pop       = out_valid && out_ready;
  assign busy      = (state != IDLE);
  assign ram_raddr = addr;
  assign out_last  = out_valid && (out_left == ONE_LEFT);

  // A beat leaving this cycle frees its slot before the next read's data lands,
  // which is what lets the reader sustain one word per cycle.
  assign occupancy = {1'b0, buf_count}
                   + {{BUF_COUNT_WIDTH{1'b0}}, in_flight}
                   - {{BUF_COUNT_WIDTH{1'b0}}, pop};

  bram_stream_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_flight),
    .wr_data (ram_rdata),
    .rd_en   (out_ready),
    .rd_data (out_data),
    .valid   (out_valid),
    .count   (buf_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      issue_left <= '0;
      out_left   <= '0;
      in_flight  <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      addr       <= addr_next;
      issue_left <= issue_left_next;
      out_left   <= out_left_next;
      in_flight  <= ram_re;
      done       <= done_next;
    end
  end

  // issue_left counts reads still to issue; out_left counts beats still to deliver.
  always_comb begin
    state_next      = state;
    addr_next       = addr;
    issue_left_next = issue_left;
    out_left_next   = out_left;
    done_next       = 1'b0;
    ram_re          = 1'b0;

    if (pop) begin
      out_left_next = out_left - 1'b1;
    end

    case (state)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_next      = RUN;
            addr_next       = base_addr;
            issue_left_next = length;
            out_left_next   = length;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      RUN: begin
        if (occupancy < BUF_LIMIT) begin
          ram_re          = 1'b1;
          addr_next       = addr + 1'b1;
          issue_left_next = issue_left - 1'b1;
          if (issue_left == ONE_LEFT) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && (out_left == ONE_LEFT)) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader: a behavioural RAM, a queue-based
// model of the expected address and data sequences, and randomized bursts.
module tb_bram_stream_reader;

  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_raddr;
  logic          ram_re;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [AW-1:0] addr_q [$];

  int tests_run    = 0;
  int tests_failed = 0;
  int beats_seen   = 0;
  int ready_mode   = 0;
  int ready_phase  = 0;

  always #5 clk = ~clk;

  bram_stream_reader #(
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .ram_raddr (ram_raddr),
    .ram_re    (ram_re),
    .ram_rdata (ram_rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  // Registered-read RAM: data appears in the cycle after the issuing edge.
  always @(posedge clk) begin
    if (ram_re) ram_rdata <= mem[ram_raddr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic pushModel(input logic [AW-1:0] b, input logic [AW:0] l);
    for (int i = 0; i < int'(l); i++) begin
      exp_q.push_back(mem[(int'(b) + i) % DEPTH]);
      addr_q.push_back(AW'((int'(b) + i) % DEPTH));
    end
  endtask

  // Sample mid-cycle: every issued address and every presented word must match the model.
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_re) begin
        if (addr_q.size() == 0) begin
          checkOutput("spurious_re", 32'(ram_re), 32'd0);
        end else begin
          checkOutput("ram_raddr", 32'(ram_raddr), 32'(addr_q[0]));
          void'(addr_q.pop_front());
        end
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_valid", 32'(out_valid), 32'd0);
        end else begin
          checkOutput("out_data", 32'(out_data), 32'(exp_q[0]));
          checkOutput("out_last", 32'(out_last), 32'(exp_q.size() == 1));
          if (out_ready) begin
            void'(exp_q.pop_front());
            beats_seen++;
          end
        end
      end
    end
  end

  // out_ready patterns: 0 = always ready, 1 = repeating 1,0,0, 2 = random.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready   = (ready_phase == 0);
          ready_phase = (ready_phase + 1) % 3;
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic applyStimulus(input logic [AW-1:0] b, input logic [AW:0] l,
                               input bit check_rate, input bit keep_start);
    int cyc;
    bit seen;
    pushModel(b, l);
    base_addr = b;
    length    = l;
    start     = 1'b1;
    @(posedge clk);
    #1;
    if (!keep_start) start = 1'b0;
    if (l == 0) begin
      checkOutput("zero_len_done", 32'(done), 32'd1);
      checkOutput("zero_len_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("zero_len_done_pulse", 32'(done), 32'd0);
      return;
    end
    checkOutput("first_re", 32'(ram_re), 32'd1);
    checkOutput("busy_set", 32'(busy), 32'd1);
    checkOutput("valid_early_n", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("valid_early_n1", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("valid_at_n2", 32'(out_valid), 32'd1);
    cyc  = 2;
    seen = 1'b0;
    while (!seen && cyc < 4 * int'(l) + 50) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) seen = 1'b1;
    end
    checkOutput("done_seen", 32'(seen), 32'd1);
    if (check_rate) checkOutput("burst_cycles", 32'(cyc), 32'(int'(l) + 2));
    checkOutput("beats_left", 32'(exp_q.size()), 32'd0);
    checkOutput("busy_cleared", 32'(busy), 32'd0);
    if (!keep_start) begin
      @(posedge clk);
      #1;
      checkOutput("done_pulse", 32'(done), 32'd0);
    end
  endtask

  initial begin
    int cyc;
    int beats_before;
    logic [AW-1:0] rb;
    logic [AW:0]   rl;

    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_last", 32'(out_last), 32'd0);
    checkOutput("rst_re", 32'(ram_re), 32'd0);
    checkOutput("rst_raddr", 32'(ram_raddr), 32'd0);
    checkOutput("rst_data", 32'(out_data), 32'd0);

    // Identity RAM, simple burst at full rate.
    ready_mode = 0;
    applyStimulus(10'h010, 11'd4, 1'b1, 1'b0);

    // Address wrap at the top of the RAM.
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    applyStimulus(10'h3FE, 11'd4, 1'b1, 1'b0);

    // Stalled consumer with a 1,0,0 ready pattern.
    ready_phase = 0;
    ready_mode  = 1;
    applyStimulus(10'h123, 11'd8, 1'b0, 1'b0);
    ready_mode = 0;

    // Zero-length request.
    applyStimulus(10'h055, 11'd0, 1'b0, 1'b0);

    // Reset after three beats of a ten-word burst.
    beats_before = beats_seen;
    pushModel(10'h200, 11'd10);
    base_addr = 10'h200;
    length    = 11'd10;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 0;
    while ((beats_seen - beats_before) < 3 && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("three_beats", 32'(beats_seen - beats_before), 32'd3);
    rst = 1'b1;
    exp_q.delete();
    addr_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_re", 32'(ram_re), 32'd0);
    checkOutput("abort_raddr", 32'(ram_raddr), 32'd0);
    checkOutput("abort_data", 32'(out_data), 32'd0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("abort_no_done", 32'(done), 32'd0);
      @(posedge clk);
      #1;
    end
    applyStimulus(10'h300, 11'd5, 1'b1, 1'b0);

    // Start held high through the done cycle: second burst follows immediately.
    applyStimulus(10'h0A0, 11'd6, 1'b1, 1'b1);
    applyStimulus(10'h3FC, 11'd7, 1'b1, 1'b0);

    // Randomized bursts.
    for (int n = 0; n < 20; n++) begin
      rb         = AW'($urandom_range(0, DEPTH - 1));
      rl         = (AW + 1)'($urandom_range(0, 40));
      ready_mode = ($urandom_range(0, 1) == 1) ? 2 : 0;
      applyStimulus(rb, rl, ready_mode == 0, 1'b0);
    end

    // Whole-RAM burst from a random base.
    ready_mode = 0;
    rb = AW'($urandom_range(0, DEPTH - 1));
    applyStimulus(rb, (AW + 1)'(DEPTH), 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
